// File: rtl/stream_sorter.sv
// ---------------------------------------------------------------------------
// stream_sorter
//   Sequential odd-even transposition sorter. Sorts one vector of N unsigned
//   WIDTH-bit elements per transaction, applying one compare/swap phase per
//   clock. Valid/ready on both sides; sort direction latched per vector.
//
//   Parameters
//     WIDTH      bits per element (>=1)
//     N          elements per vector (even, >=2)
//
//   Ports
//     clk        rising-edge clock
//     nrst       asynchronous active-low reset
//     in_valid   input vector offered
//     in_ready   sorter idle and able to accept
//     in_data    N*WIDTH packed vector, element k at [k*WIDTH +: WIDTH]
//     in_desc    0 ascending (element 0 smallest), 1 descending
//     out_valid  sorted vector held on out_data
//     out_ready  consumer accepts
//     out_data   working register, same packing as in_data
//     busy       sort phases in progress
//
//   Build option
//     STREAM_SORTER_EARLY_EXIT_EN : finish as soon as an even and an odd
//     phase in a row make no swaps (never later than phase N-1).
// ---------------------------------------------------------------------------

// One compare/swap cell for the pair (a = lower index, b = higher index).
module stream_sorter_cas #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             desc,
   input  logic             en,
   output logic             swp
);
   // strict compares: equal keys never swap
   assign swp = en & (desc ? (a < b) : (a > b));
endmodule

module stream_sorter #(
   parameter int WIDTH = 4,
   parameter int N     = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_desc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic               busy
);
   localparam int PW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                    state;
   logic [N-1:0][WIDTH-1:0]   work;
   logic [N-1:0][WIDTH-1:0]   nxt;
   logic                      desc_q;
   logic [PW-1:0]             phase;
   logic [N-2:0]              sw;     // sw[i]: pair (i,i+1) swaps this cycle
   logic                      last_phase;

   assign in_ready   = nrst && (state == IDLE);
   assign out_valid  = (state == DONE);
   assign busy       = (state == SORT);
   assign out_data   = work;
   assign last_phase = (phase == PW'(N-1));

   // Pair i is active on phases whose parity matches i: even phases take
   // (0,1),(2,3)..., odd phases take (1,2),(3,4)... Active pairs never
   // overlap, so each element is moved by at most one cell.
   for (genvar i = 0; i < N-1; i++) begin : g_pair
      localparam bit PAR = (i % 2) == 1;
      stream_sorter_cas #(.WIDTH(WIDTH)) u_cas (
         .a    (work[i]),
         .b    (work[i+1]),
         .desc (desc_q),
         .en   ((state == SORT) && (phase[0] == PAR)),
         .swp  (sw[i])
      );
   end

   for (genvar k = 0; k < N; k++) begin : g_elem
      if (k == 0) begin : g_first
         assign nxt[k] = sw[k] ? work[k+1] : work[k];
      end else if (k == N-1) begin : g_last
         assign nxt[k] = sw[k-1] ? work[k-1] : work[k];
      end else begin : g_mid
         assign nxt[k] = sw[k]   ? work[k+1] :
                         sw[k-1] ? work[k-1] : work[k];
      end
   end

`ifdef STREAM_SORTER_EARLY_EXIT_EN
   logic any_sw;
   logic clean_q;   // previous phase made no swaps
   assign any_sw = |sw;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         work    <= '0;
         desc_q  <= 1'b0;
         phase   <= '0;
`ifdef STREAM_SORTER_EARLY_EXIT_EN
         clean_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work    <= in_data;
                  desc_q  <= in_desc;
                  phase   <= '0;
`ifdef STREAM_SORTER_EARLY_EXIT_EN
                  clean_q <= 1'b0;
`endif
                  state   <= SORT;
               end
            end
            SORT: begin
               work  <= nxt;
               phase <= phase + PW'(1);
`ifdef STREAM_SORTER_EARLY_EXIT_EN
               clean_q <= ~any_sw;
               // clean_q is only set after phase 0, so this pairs one even
               // and one odd phase
               if (last_phase || (clean_q && !any_sw)) state <= DONE;
`else
               if (last_phase) state <= DONE;
`endif
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stream_sorter.sv
// ---------------------------------------------------------------------------
// tb_stream_sorter
//   Directed bench for stream_sorter: a WIDTH=4/N=4 instance for the main
//   vectors, backpressure and reset abort, and a WIDTH=8/N=8 instance for the
//   reverse-order vector. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_stream_sorter;
`ifdef STREAM_SORTER_EARLY_EXIT_EN
   localparam int LAT_CLEAN = 2;
`else
   localparam int LAT_CLEAN = 4;
`endif

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   // 4x4 instance
   logic        a_ivld, a_irdy, a_idesc, a_ovld, a_ordy, a_busy;
   logic [15:0] a_idata, a_odata;
   // 8x8 instance
   logic        b_ivld, b_irdy, b_idesc, b_ovld, b_ordy, b_busy;
   logic [63:0] b_idata, b_odata;

   stream_sorter #(.WIDTH(4), .N(4)) u_dut4 (
      .clk(clk), .nrst(nrst),
      .in_valid(a_ivld), .in_ready(a_irdy), .in_data(a_idata), .in_desc(a_idesc),
      .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_odata), .busy(a_busy)
   );

   stream_sorter #(.WIDTH(8), .N(8)) u_dut8 (
      .clk(clk), .nrst(nrst),
      .in_valid(b_ivld), .in_ready(b_irdy), .in_data(b_idata), .in_desc(b_idesc),
      .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_odata), .busy(b_busy)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // wait for out_valid on the 4x4 instance, counting cycles and busy cycles
   task automatic wait_out4(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (!a_ovld && lat < 50) begin
         if (a_busy) bcnt++;
         tick;
         lat++;
      end
   endtask

   task automatic send4(input logic [15:0] d, input logic desc);
      int w = 0;
      while (!a_irdy && w < 50) begin tick; w++; end
      chk("send4.ready", a_irdy, 1);
      a_ivld = 1; a_idata = d; a_idesc = desc;
      tick;                                  // accept edge E0
      a_ivld = 0; a_idata = ~d; a_idesc = ~desc;   // post-accept changes ignored
   endtask

   task automatic run4(input string tag, input logic [15:0] d, input logic desc,
                       input logic [15:0] exp, input int lat_exp);
      int lat, bc;
      send4(d, desc);
      wait_out4(lat, bc);
      chk({tag, ".lat"},  lat, lat_exp);
      chk({tag, ".busy"}, bc, lat_exp);
      chk({tag, ".data"}, a_odata, exp);
      a_ordy = 1;
      tick;                                  // output handshake
      a_ordy = 0;
      chk({tag, ".ovld_lo"}, a_ovld, 0);
      chk({tag, ".irdy_hi"}, a_irdy, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc;
      a_ivld = 0; a_idata = '0; a_idesc = 0; a_ordy = 0;
      b_ivld = 0; b_idata = '0; b_idesc = 0; b_ordy = 0;

      // reset state
      #12;
      chk("rst.irdy",  a_irdy, 0);
      chk("rst.ovld",  a_ovld, 0);
      chk("rst.busy",  a_busy, 0);
      chk("rst.odata", a_odata, 0);
      @(negedge clk); nrst = 1; #1;
      chk("rst.irdy_rel", a_irdy, 1);
      tick;

      // basic vectors
      run4("asc",      16'h1A3F, 1'b0, 16'hFA31, 4);
      run4("desc",     16'h1A3F, 1'b1, 16'h13AF, 4);
      run4("eq_asc",   16'h5555, 1'b0, 16'h5555, LAT_CLEAN);
      run4("eq_desc",  16'h5555, 1'b1, 16'h5555, LAT_CLEAN);
      run4("sorted",   16'hFA31, 1'b0, 16'hFA31, LAT_CLEAN);
      run4("dup_asc",  16'h2727, 1'b0, 16'h7722, 4);

      // backpressure: out_ready low 5 cycles with a new vector waiting
      send4(16'h1A3F, 1'b0);
      wait_out4(lat, bc);
      chk("bp.lat", lat, 4);
      a_ivld = 1; a_idata = 16'h0C84; a_idesc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp.data%0d", i), a_odata, 16'hFA31);
         chk($sformatf("bp.irdy%0d", i), a_irdy, 0);
         chk($sformatf("bp.ovld%0d", i), a_ovld, 1);
         tick;
      end
      a_ordy = 1;
      tick;                                  // handshake edge D
      a_ordy = 0;
      chk("bp.ovld_after", a_ovld, 0);
      chk("bp.irdy_after", a_irdy, 1);
      chk("bp.busy_after", a_busy, 0);
      tick;                                  // D+1: new vector accepted
      a_ivld = 0;
      chk("bp.busy_acc", a_busy, 1);
      chk("bp.irdy_acc", a_irdy, 0);
      wait_out4(lat, bc);
      chk("bp.lat2",  lat, 4);
      chk("bp.data2", a_odata, 16'hC840);
      a_ordy = 1; tick; a_ordy = 0;

      // reset mid-sort
      send4(16'h1A3F, 1'b0);
      tick; tick;
      #2 nrst = 0;
      #1;
      chk("rst_mid.ovld",  a_ovld, 0);
      chk("rst_mid.odata", a_odata, 0);
      chk("rst_mid.busy",  a_busy, 0);
      chk("rst_mid.irdy",  a_irdy, 0);
      @(negedge clk); @(negedge clk);
      nrst = 1; #1;
      chk("rst_mid.irdy_rel", a_irdy, 1);
      run4("post_rst", 16'h1A3F, 1'b1, 16'h13AF, 4);

      // 8x8 reverse-order vector, ascending
      b_ivld = 1; b_idata = 64'h0001020304050607; b_idesc = 1'b0;
      tick;
      b_ivld = 0; b_idata = '0;
      lat = 0;
      while (!b_ovld && lat < 50) begin tick; lat++; end
      chk("n8.lat",  lat, 8);
      chk("n8.data", b_odata, 64'h0706050403020100);
      b_ordy = 1; tick; b_ordy = 0;
      chk("n8.ovld_lo", b_ovld, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
